// File: rtl/fp12_mul_unit_if.sv
// Operand/product bundle for the FP12 multiplier.
// The master drives both operands; the slave returns the product.
interface fp12_mul_unit_if #(
    parameter int W = 12
);
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic [W-1:0] out;

    modport master (output in1, output in2, input out);
    modport slave  (input in1, input in2, output out);
endinterface

// File: rtl/fp12_mul_unit.sv
// FP12 multiplier: sign | 3-bit exponent (bias 3) | 8-bit fraction, RNE rounding, saturate/flush.
// Define FP12_MULT_OUT_REG_EN to register the product (1-cycle latency, async clear on rst).
module fp12_mul_unit #(
    parameter int EXP_W = 3,
    parameter int MAN_W = 8,
    parameter int BIAS  = 3
) (
    input  logic          clk,
    input  logic          rst,
    fp12_mul_unit_if.slave bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int SW = MAN_W + 1;
    localparam int PW = 2 * SW;
    localparam int EW = EXP_W + 3;
    localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] EXP_MIN = EW'(1);

    logic                    sign;
    logic                    zero_op;
    logic [EXP_W-1:0]        e1, e2;
    logic [SW-1:0]           sig_a, sig_b;
    logic [PW-1:0]           prod;
    logic                    norm;
    logic [MAN_W-1:0]        frac;
    logic                    guard, sticky, rnd_up;
    logic [SW-1:0]           rnd;
    logic signed [EW-1:0]    exp_s;
    logic [W-1:0]            res_c;

    always_comb begin
        sign    = bus.in1[W-1] ^ bus.in2[W-1];
        e1      = bus.in1[W-2:MAN_W];
        e2      = bus.in2[W-2:MAN_W];
        zero_op = (e1 == '0) || (e2 == '0);
        sig_a   = {1'b1, bus.in1[MAN_W-1:0]};
        sig_b   = {1'b1, bus.in2[MAN_W-1:0]};
        prod    = PW'(sig_a) * PW'(sig_b);
        norm    = prod[PW-1];

        if (norm) begin
            frac   = prod[PW-2:MAN_W+1];
            guard  = prod[MAN_W];
            sticky = |prod[MAN_W-1:0];
        end else begin
            frac   = prod[PW-3:MAN_W];
            guard  = prod[MAN_W-1];
            sticky = |prod[MAN_W-2:0];
        end

        // Ties go up only when the kept LSB is odd; rnd[MAN_W] is the carry out of the fraction.
        rnd_up = guard & (sticky | frac[0]);
        rnd    = {1'b0, frac} + SW'(rnd_up);
        exp_s  = EW'(e1) + EW'(e2) - EW'(BIAS) + EW'(norm) + EW'(rnd[MAN_W]);

        if (zero_op || (exp_s < EXP_MIN))
            res_c = {sign, {(W-1){1'b0}}};
        else if (exp_s > EXP_MAX)
            res_c = {sign, {(W-1){1'b1}}};
        else
            res_c = {sign, exp_s[EXP_W-1:0], rnd[MAN_W-1:0]};
    end

`ifdef FP12_MULT_OUT_REG_EN
    logic [W-1:0] out_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            out_q <= '0;
        else
            out_q <= res_c;
    end

    assign bus.out = out_q;
`else
    logic unused_clk_rst;

    assign unused_clk_rst = clk ^ rst;
    assign bus.out        = res_c;
`endif
endmodule

// File: tb/tb_fp12_mul_unit.sv
// Self-checking bench for fp12_mul_unit: directed vectors plus random pairs against an integer model.
// Works for both builds; FP12_MULT_OUT_REG_EN selects the 1-cycle latency and reset checks.
module tb_fp12_mul_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;
    logic [11:0] prev_exp = '0;

    fp12_mul_unit_if bus ();

    fp12_mul_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Value-level model: exact integer product, normalise by searching for the 9-bit window, RNE via remainder.
    function automatic logic [11:0] ref_mul(input logic [11:0] a, input logic [11:0] b);
        int     e1, e2, k, e;
        longint p, q, r, half;
        logic   s;
        s  = a[11] ^ b[11];
        e1 = int'(a[10:8]);
        e2 = int'(b[10:8]);
        if (e1 == 0 || e2 == 0) return {s, 11'b0};
        p = longint'(256 + int'(a[7:0])) * longint'(256 + int'(b[7:0]));
        k = 0;
        while ((p >> k) >= 512) k++;
        q    = p >> k;
        r    = p - (q << k);
        half = longint'(1) << (k - 1);
        if (r > half || (r == half && (q % 2) == 1)) q++;
        if (q == 512) begin
            q = 256;
            k++;
        end
        e = e1 + e2 - 3 + (k - 8);
        if (e > 7) return {s, 3'b111, 8'hFF};
        if (e < 1) return {s, 11'b0};
        return {s, 3'(e), 8'(q - 256)};
    endfunction

    task automatic run_pair(input string tag, input logic [11:0] a, input logic [11:0] b,
                            input logic [11:0] exp);
        @(negedge clk);
        bus.in1 = a;
        bus.in2 = b;
`ifdef FP12_MULT_OUT_REG_EN
        #1;
        check_eq({tag, "_hold"}, bus.out, prev_exp);
        @(posedge clk);
        #1;
`else
        #1;
`endif
        check_eq(tag, bus.out, exp);
        prev_exp = exp;
    endtask

    logic [11:0] da [6] = '{12'h355, 12'h30A, 12'h3FF, 12'h700, 12'h100, 12'h000};
    logic [11:0] db [6] = '{12'h575, 12'hEC0, 12'hEFF, 12'h700, 12'h100, 12'h8AB};
    logic [11:0] de [6] = '{12'h5F1, 12'hED2, 12'hFFE, 12'h7FF, 12'h000, 12'h800};

    initial begin
        logic [11:0] a, b;
        bus.in1 = 12'h355;
        bus.in2 = 12'h575;
        #12;
`ifdef FP12_MULT_OUT_REG_EN
        check_eq("reset_out", bus.out, 12'h000);
        @(posedge clk);
        #1;
        check_eq("reset_hold_edge", bus.out, 12'h000);
`else
        check_eq("comb_under_rst", bus.out, 12'h5F1);
`endif
        @(negedge clk);
        rst = 1'b0;
        prev_exp = '0;

        for (int i = 0; i < 6; i++)
            run_pair($sformatf("directed%0d", i), da[i], db[i], de[i]);

        run_pair("round_carry_norm", 12'h3FF, 12'h380, ref_mul(12'h3FF, 12'h380));
        run_pair("max_times_one", 12'h7FF, 12'h300, ref_mul(12'h7FF, 12'h300));
        run_pair("underflow_edge", 12'h1FF, 12'h1FF, ref_mul(12'h1FF, 12'h1FF));

        // Mid-stream reset between clock edges.
        run_pair("pre_reset", 12'h355, 12'h575, 12'h5F1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
`ifdef FP12_MULT_OUT_REG_EN
        check_eq("async_clear", bus.out, 12'h000);
        prev_exp = '0;
`else
        check_eq("rst_ignored", bus.out, 12'h5F1);
`endif
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 300; i++) begin
            a = 12'($urandom);
            b = 12'($urandom);
            run_pair($sformatf("rand%0d", i), a, b, ref_mul(a, b));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
